arm_ctrl_fsm: RTL and testbench
===============================

# arm_ctrl_fsm

Multi-cycle control state machine for the branch-capable ARM core. It sequences the instruction-fetch/PC block by driving `Write_IR`, `Write_PC` and `PC_s`, and consumes that block's condition result `flag` and latched `IR`. It also drives register-file, ALU-operand and flag-update strobes for data-processing, B, BL and BX instructions, and keeps a retired-instruction counter.

## Interface
- `CNT_W`, 16: width of the retired-instruction counter.

- `clk`  in  1  system clock. The FSM updates on posedge; the fetch block samples strobes on negedge.
- `Rst`  in  1  asynchronous, active-low reset.
- `halt`  in  1  hold in IDLE instead of starting a fetch.
- `flag`  in  1  condition-pass result for the instruction being fetched.
- `IR`  in  28  latched instruction bits. `IR[k+1]` = instruction bit k.
- `Write_IR`, `Write_PC`  out  1  fetch-block strobes.
- `PC_s`  out  2  PC source: `00` PC+4, `01` register B (BX), `10` ALU result F (B/BL).
- `LA`, `LB`, `LF`  out  1  load A/B operand registers and F result register.
- `Write_Reg`  out  1  register-file write enable.
- `rd_s`  out  1  destination select: 0 = `IR[16:13]`, 1 = R14.
- `wd_s`  out  1  write-data select: 0 = F, 1 = PC.
- `alu_a_s`  out  1  ALU A operand: 0 = A, 1 = PC.
- `alu_b_s`  out  2  ALU B operand: `00` = B, `01` = zero-extended `IR[8:1]` immediate, `10` = sign-extended `IR[24:1]` shifted left by 2.
- `ALU_OP`  out  4  ALU operation code.
- `Write_NZCV`  out  1  update the flag register.
- `state`  out  4  current state encoding, for debug.
- `retire_cnt`  out  `CNT_W`  count of retired instructions.

## Operation
- Instruction classes, decoded from `IR` in DECODE:
  - **BX**: `IR[28:5]` = 24'h12FFF1.
  - **B/BL**: `IR[28:26]` = 3'b101. L bit = `IR[25]`.
  - **DP**: `IR[28:27]` = 2'b00 and not BX. Opcode = `IR[25:22]`, S bit = `IR[21]`, immediate bit = `IR[26]`.
  - **Other**: no-op; return to FETCH.
- States and outputs. Every output not listed is 0.
  - **IDLE**: no outputs. Go to FETCH when `halt`=0.
  - **FETCH**: `Write_IR`=1, `Write_PC`=1, `PC_s`=00.
    - `flag`=1: go to DECODE.
    - `flag`=0: the instruction is skipped (IR is not loaded). Go to FETCH, or to IDLE if `halt`=1.
  - **DECODE**: `LA`=1, `LB`=1. Go to EXEC_DP, BL_LINK (BL), BR_CALC (B), BX_JUMP or FETCH (other).
  - **EXEC_DP**: `LF`=1, `ALU_OP` = opcode, `alu_b_s` = {1'b0, `IR[26]`}. Go to WB_DP.
  - **WB_DP**: `Write_Reg`=1 unless the opcode is 4'b10xx (TST/TEQ/CMP/CMN). `Write_NZCV` = S bit. Go to FETCH.
  - **BL_LINK**: `Write_Reg`=1, `rd_s`=1, `wd_s`=1. Go to BR_CALC.
  - **BR_CALC**: `LF`=1, `alu_a_s`=1, `alu_b_s`=10, `ALU_OP`=4'b0100 (ADD). Go to BR_JUMP.
  - **BR_JUMP**: `Write_PC`=1, `PC_s`=10. Go to FETCH.
  - **BX_JUMP**: `Write_PC`=1, `PC_s`=01. Go to FETCH.
- `halt` is sampled only in IDLE and in FETCH. Any instruction already past FETCH always completes.
- Retire counting:
  - `retire_cnt` increments by 1 on every transition into FETCH from a state other than FETCH or IDLE.
  - Skipped instructions do not increment it.
  - The counter wraps modulo 2^`CNT_W`.

## Timing
- Reset:
  - `Rst`=0 forces IDLE immediately and clears `retire_cnt`, regardless of clock.
  - All outputs are 0 during reset, including `state`=0 (IDLE).
  - Reset asserted mid-instruction abandons that instruction with no further strobes.
- Outputs are Moore (decoded from the state register only) and glitch-free through the following negedge.
- Cycle counts from FETCH to the next FETCH:
  - DP: 4 cycles.
  - B: 4 cycles.
  - BL: 5 cycles.
  - BX: 3 cycles.
  - Other: 2 cycles.
  - Skipped: 1 cycle.
- From reset release with `halt`=0: the first FETCH occurs on the 2nd posedge.

## Structure
- Shared package `arm_ctrl_pkg` holds:
  - state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_DP=3, WB_DP=4, BL_LINK=5, BR_CALC=6, BR_JUMP=7, BX_JUMP=8;
  - `PC_s` and `alu_b_s` select constants;
  - the ADD opcode;
  - the BX match pattern.
- One sub-module: `arm_inst_class`, a combinational IR-to-class decoder with outputs `is_dp`, `is_b`, `is_bl`, `is_bx`. The FSM and the counter live in the top module.

## Test plan
- Reset then release with `halt`=0: all outputs 0 during reset; `state` = 1 at the 2nd posedge; `Write_IR`=`Write_PC`=1, `PC_s`=00.
- ADDS R1,R2,R3 (`IR` = 28'h0921003 with instruction bits shifted, `flag`=1):
  - state sequence 1,2,3,4,1;
  - `ALU_OP`=4'b0100 in EXEC_DP;
  - `Write_Reg`=1 and `Write_NZCV`=1 in WB_DP;
  - `retire_cnt` = 1.
- CMP: `Write_Reg`=0 and `Write_NZCV`=1 in WB_DP.
- BL with `flag`=1:
  - sequence 1,2,5,6,7,1;
  - `rd_s`=`wd_s`=1 in BL_LINK;
  - `PC_s`=10 in BR_JUMP.
- BX R0:
  - sequence 1,2,8,1;
  - `PC_s`=01 in BX_JUMP.
- Condition fail (`flag`=0) on three consecutive fetches: remains in FETCH with `retire_cnt` unchanged.
- `halt`=1 during a fetch that skips: next state is IDLE, with no strobes.
- Reset pulse asserted in EXEC_DP: immediate return to IDLE, `retire_cnt`=0.
- Counter wrap with `CNT_W`=4: 16 DP instructions return `retire_cnt` to 0.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: state encodings and datapath select constants shared by the ARM control FSM.
package arm_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_DP = 4'd3,
    S_WB_DP   = 4'd4,
    S_BL_LINK = 4'd5,
    S_BR_CALC = 4'd6,
    S_BR_JUMP = 4'd7,
    S_BX_JUMP = 4'd8
  } state_e;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REG = 2'b01;
  localparam logic [1:0] PC_ALU = 2'b10;
  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_IMM    = 2'b01;
  localparam logic [1:0] ALUB_BRANCH = 2'b10;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [23:0] BX_PATTERN = 24'h12FFF1;
  // TST/TEQ/CMP/CMN only update flags, never the register file
  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction
endpackage

// File: rtl/arm_ctrl_fsm_inst_class.sv
// arm_inst_class: combinational IR-to-instruction-class decoder (IR[k+1] holds instruction bit k).
module arm_inst_class
  import arm_ctrl_pkg::*;
(
  input  logic [28:1] ir_i,
  output logic        is_dp,
  output logic        is_b,
  output logic        is_bl,
  output logic        is_bx
);
  assign is_bx = ir_i[28:5] == BX_PATTERN;
  assign is_b  = ir_i[28:26] == 3'b101 && !ir_i[25];
  assign is_bl = ir_i[28:26] == 3'b101 && ir_i[25];
  assign is_dp = ir_i[28:27] == 2'b00 && !is_bx;
endmodule

// File: rtl/arm_ctrl_fsm.sv
// arm_ctrl_fsm: multi-cycle fetch/decode/execute sequencer for DP, B, BL and BX with a retire counter.
module arm_ctrl_fsm
  import arm_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             halt,
  input  logic             flag,
  input  logic [28:1]      IR,
  output logic             Write_IR,
  output logic             Write_PC,
  output logic [1:0]       PC_s,
  output logic             LA,
  output logic             LB,
  output logic             LF,
  output logic             Write_Reg,
  output logic             rd_s,
  output logic             wd_s,
  output logic             alu_a_s,
  output logic [1:0]       alu_b_s,
  output logic [3:0]       ALU_OP,
  output logic             Write_NZCV,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);
  state_e           state_q, state_d;
  logic             arm_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_dp, is_b, is_bl, is_bx;
  logic             retire;

  arm_inst_class u_class (
    .ir_i  (IR),
    .is_dp (is_dp),
    .is_b  (is_b),
    .is_bl (is_bl),
    .is_bx (is_bx)
  );

  // arm_q holds IDLE for one extra edge after reset release
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= 1'b1;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign retire = state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = (arm_q && !halt) ? S_FETCH : S_IDLE;
      S_FETCH:   state_d = flag ? S_DECODE : (halt ? S_IDLE : S_FETCH);
      S_DECODE:  state_d = is_dp ? S_EXEC_DP : is_bl ? S_BL_LINK : is_b ? S_BR_CALC :
                           is_bx ? S_BX_JUMP : S_FETCH;
      S_EXEC_DP: state_d = S_WB_DP;
      S_WB_DP:   state_d = S_FETCH;
      S_BL_LINK: state_d = S_BR_CALC;
      S_BR_CALC: state_d = S_BR_JUMP;
      S_BR_JUMP: state_d = S_FETCH;
      S_BX_JUMP: state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Write_IR   = 1'b0;
    Write_PC   = 1'b0;
    PC_s       = PC_INC;
    LA         = 1'b0;
    LB         = 1'b0;
    LF         = 1'b0;
    Write_Reg  = 1'b0;
    rd_s       = 1'b0;
    wd_s       = 1'b0;
    alu_a_s    = 1'b0;
    alu_b_s    = ALUB_REG;
    ALU_OP     = 4'b0000;
    Write_NZCV = 1'b0;
    case (state_q)
      S_FETCH: begin
        Write_IR = 1'b1;
        Write_PC = 1'b1;
      end
      S_DECODE: begin
        LA = 1'b1;
        LB = 1'b1;
      end
      S_EXEC_DP: begin
        LF      = 1'b1;
        ALU_OP  = IR[25:22];
        alu_b_s = IR[26] ? ALUB_IMM : ALUB_REG;
      end
      S_WB_DP: begin
        Write_Reg  = !is_test_op(IR[25:22]);
        Write_NZCV = IR[21];
      end
      S_BL_LINK: begin
        Write_Reg = 1'b1;
        rd_s      = 1'b1;
        wd_s      = 1'b1;
      end
      S_BR_CALC: begin
        LF      = 1'b1;
        alu_a_s = 1'b1;
        alu_b_s = ALUB_BRANCH;
        ALU_OP  = OP_ADD;
      end
      S_BR_JUMP: begin
        Write_PC = 1'b1;
        PC_s     = PC_ALU;
      end
      S_BX_JUMP: begin
        Write_PC = 1'b1;
        PC_s     = PC_REG;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign retire_cnt = cnt_q;
endmodule

// File: tb/tb_arm_ctrl_fsm.sv
// tb_arm_ctrl_fsm: directed ARM instruction stream checked every negedge against an instruction-level model.
module tb_arm_ctrl_fsm;
  localparam int W = 4;
  localparam logic [28:1] I_ADDS = 28'h0921003;
  localparam logic [28:1] I_CMP  = 28'h1510002;
  localparam logic [28:1] I_BL   = 28'hB000004;
  localparam logic [28:1] I_B    = 28'hA000004;
  localparam logic [28:1] I_BX   = 28'h12FFF10;
  localparam logic [28:1] I_LDR  = 28'h5900000;
  localparam logic [28:1] I_MOVI = 28'h3A00005;

  logic clk = 1'b0, Rst = 1'b0, halt = 1'b0, flag = 1'b1;
  logic [28:1] IR = I_LDR;
  logic Write_IR, Write_PC, LA, LB, LF, Write_Reg, rd_s, wd_s, alu_a_s, Write_NZCV;
  logic [1:0] PC_s, alu_b_s;
  logic [3:0] ALU_OP, state;
  logic [W-1:0] retire_cnt;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  arm_ctrl_fsm #(.CNT_W(W)) dut (
    .clk(clk), .Rst(Rst), .halt(halt), .flag(flag), .IR(IR),
    .Write_IR(Write_IR), .Write_PC(Write_PC), .PC_s(PC_s), .LA(LA), .LB(LB), .LF(LF),
    .Write_Reg(Write_Reg), .rd_s(rd_s), .wd_s(wd_s), .alu_a_s(alu_a_s), .alu_b_s(alu_b_s),
    .ALU_OP(ALU_OP), .Write_NZCV(Write_NZCV), .state(state), .retire_cnt(retire_cnt)
  );

  wire [21:0] dut_vec = {Write_IR, Write_PC, PC_s, LA, LB, LF, Write_Reg, rd_s, wd_s,
                         alu_a_s, alu_b_s, ALU_OP, Write_NZCV, state};

  // Instruction-level model: each fetched instruction expands into its list of phases
  int m_state = 0, m_cnt = 0;
  bit m_arm = 0;
  int path[$];

  task automatic plan(input logic [27:0] ins);
    path.delete();
    path.push_back(2);
    if (ins[27:4] == 24'h12FFF1) path.push_back(8);
    else if (ins[27:25] == 3'b101) begin
      if (ins[24]) path.push_back(5);
      path.push_back(6);
      path.push_back(7);
    end else if (ins[27:26] == 2'b00) begin
      path.push_back(3);
      path.push_back(4);
    end
  endtask

  function automatic logic [21:0] expect_out(input int s, input logic [27:0] ins);
    logic wir = 0, wpc = 0, la = 0, lb = 0, lf = 0, wreg = 0, rds = 0, wds = 0, aas = 0, nzcv = 0;
    logic [1:0] pcs = 0, abs = 0;
    logic [3:0] op = 0;
    case (s)
      1: begin wir = 1; wpc = 1; end
      2: begin la = 1; lb = 1; end
      3: begin lf = 1; op = ins[24:21]; abs = {1'b0, ins[25]}; end
      4: begin wreg = (ins[24:23] != 2'b10); nzcv = ins[20]; end
      5: begin wreg = 1; rds = 1; wds = 1; end
      6: begin lf = 1; aas = 1; abs = 2'b10; op = 4'd4; end
      7: begin wpc = 1; pcs = 2'b10; end
      8: begin wpc = 1; pcs = 2'b01; end
      default: ;
    endcase
    return {wir, wpc, pcs, la, lb, lf, wreg, rds, wds, aas, abs, op, nzcv, 4'(s)};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge Rst);
      if (!Rst) begin
        m_state = 0;
        m_cnt = 0;
        m_arm = 0;
        path.delete();
      end else if (m_state == 0) begin
        if (m_arm && !halt) m_state = 1;
        m_arm = 1;
      end else if (m_state == 1) begin
        if (flag) begin
          plan(IR);
          m_state = path.pop_front();
        end else m_state = halt ? 0 : 1;
      end else if (path.size() != 0) m_state = path.pop_front();
      else begin
        m_state = 1;
        m_cnt = (m_cnt + 1) % (1 << W);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      n_vec++;
      if (dut_vec !== expect_out(m_state, IR)) begin
        n_bad++;
        $display("FAIL outputs t=%0t: got %h want %h", $time, dut_vec, expect_out(m_state, IR));
      end
      n_vec++;
      if (retire_cnt !== W'(m_cnt)) begin
        n_bad++;
        $display("FAIL retire_cnt t=%0t: got %0d want %0d", $time, retire_cnt, m_cnt);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int want);
    tick();
    chk("state", int'(state), want);
  endtask

  initial begin
    tick();
    tick();
    chk("reset state", int'(state), 0);
    chk("reset strobes", int'(dut_vec), 0);
    Rst = 1'b1;
    IR = I_ADDS;
    step(0);
    step(1);
    chk("fetch Write_IR", int'(Write_IR), 1);
    chk("fetch Write_PC", int'(Write_PC), 1);
    chk("fetch PC_s", int'(PC_s), 0);
    step(2);
    step(3);
    chk("adds ALU_OP", int'(ALU_OP), 4);
    step(4);
    chk("adds Write_Reg", int'(Write_Reg), 1);
    chk("adds Write_NZCV", int'(Write_NZCV), 1);
    step(1);
    chk("adds retire", int'(retire_cnt), 1);
    IR = I_CMP;
    step(2); step(3); step(4);
    chk("cmp Write_Reg", int'(Write_Reg), 0);
    chk("cmp Write_NZCV", int'(Write_NZCV), 1);
    step(1);
    IR = I_BL;
    step(2); step(5);
    chk("bl rd_s", int'(rd_s), 1);
    chk("bl wd_s", int'(wd_s), 1);
    step(6); step(7);
    chk("bl PC_s", int'(PC_s), 2);
    step(1);
    IR = I_B;
    step(2); step(6); step(7); step(1);
    IR = I_BX;
    step(2); step(8);
    chk("bx PC_s", int'(PC_s), 1);
    step(1);
    IR = I_LDR;
    step(2); step(1);
    chk("other retire", int'(retire_cnt), 6);
    IR = I_MOVI;
    step(2); step(3);
    chk("movi alu_b_s", int'(alu_b_s), 1);
    chk("movi ALU_OP", int'(ALU_OP), 13);
    step(4); step(1);
    flag = 1'b0;
    step(1); step(1); step(1);
    chk("skip retire", int'(retire_cnt), 7);
    halt = 1'b1;
    step(0);
    chk("halt strobes", int'({Write_IR, Write_PC}), 0);
    step(0);
    halt = 1'b0;
    step(1);
    halt = 1'b1;
    flag = 1'b1;
    IR = I_ADDS;
    step(2); step(3); step(4); step(1);
    flag = 1'b0;
    step(0);
    halt = 1'b0;
    flag = 1'b1;
    step(1);
    step(2); step(3);
    Rst = 1'b0;
    #1;
    chk("async reset state", int'(state), 0);
    chk("async reset strobes", int'(dut_vec), 0);
    chk("async reset retire", int'(retire_cnt), 0);
    tick();
    Rst = 1'b1;
    step(0);
    step(1);
    for (int i = 0; i < 16; i++) begin
      step(2); step(3); step(4); step(1);
      chk("wrap retire", int'(retire_cnt), (i + 1) % 16);
    end
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
